// File: rtl/spi_periph_bridge_if.sv
// SPI pad-side pins plus the TinyQV-style peripheral bus driven by the bridge.
// master = bridge side, slave = harness side (SPI master and peripherals).
interface spi_periph_bridge_if #(
   parameter int ADDR_W = 6,
   parameter int NCH    = 4
);
   logic                spi_cs_n;
   logic                spi_clk;
   logic                spi_mosi;
   logic                spi_miso;
   logic [ADDR_W-1:0]   address;
   logic [31:0]         data_in;
   logic [2*NCH-1:0]    data_write_n;
   logic [2*NCH-1:0]    data_read_n;
   logic [32*NCH-1:0]   data_out;
   logic [NCH-1:0]      data_ready;
   logic                busy;
   logic                err;

   modport master (
      input  spi_cs_n, spi_clk, spi_mosi, data_out, data_ready,
      output spi_miso, address, data_in, data_write_n, data_read_n, busy, err
   );

   modport slave (
      output spi_cs_n, spi_clk, spi_mosi, data_out, data_ready,
      input  spi_miso, address, data_in, data_write_n, data_read_n, busy, err
   );
endinterface

// File: rtl/spi_periph_bridge.sv
// SPI mode-0 slave to NCH-channel register bus: write strobe 1 clk after the last data bit;
// reads hold the strobe until data_ready or TIMEOUT while the master clocks a turnaround byte.
module spi_periph_bridge #(
   parameter int ADDR_W  = 6,
   parameter int NCH     = 4,
   parameter int TIMEOUT = 16
) (
   input logic                 clk,
   input logic                 rst,
   spi_periph_bridge_if.master bus
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {IDLE, HDR, WDATA, WSTB, RWAIT, RDATA, DROP} state_t;

   state_t            state;
   logic              sck_q;
   logic              cs_q;
   logic [31:0]       sh;
   logic [5:0]        cnt;
   logic [4:0]        tcnt;
   logic [1:0]        w;
   logic              ai;
   logic [CH_W-1:0]   ch;
   logic              cap_done;

   logic              rise;
   logic              fall;
   logic [31:0]       sin;
   logic [1:0]        hdr_w;
   logic [5:0]        last_idx;
   logic [ADDR_W-1:0] step;
   logic              sel_rdy;
   logic [31:0]       sel_dat;

   assign rise     = bus.spi_clk & ~sck_q;
   assign fall     = ~bus.spi_clk & sck_q;
   assign sin      = {sh[30:0], bus.spi_mosi};
   assign hdr_w    = (sin[14:13] == 2'b11) ? 2'b10 : sin[14:13];
   assign last_idx = (w == 2'b00) ? 6'd7 : (w == 2'b01) ? 6'd15 : 6'd31;
   assign step     = ADDR_W'(4'd1 << w);

   always_comb begin
      sel_rdy = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch == CH_W'(i)) begin
            sel_rdy = bus.data_ready[i];
            sel_dat = bus.data_out[32*i +: 32];
         end
      end
   end

   function automatic logic [2*NCH-1:0] strobe(input logic [CH_W-1:0] c, input logic [1:0] code);
      logic [2*NCH-1:0] v;
      v = '1;
      for (int i = 0; i < NCH; i++) begin
         if (c == CH_W'(i)) v[2*i +: 2] = code;
      end
      return v;
   endfunction

   function automatic logic [31:0] fit(input logic [31:0] v, input logic [1:0] code);
      case (code)
         2'b00:   fit = {24'd0, v[7:0]};
         2'b01:   fit = {16'd0, v[15:0]};
         default: fit = v;
      endcase
   endfunction

   // Read beats are left-aligned so MISO always shifts out of bit 31.
   function automatic logic [31:0] align(input logic [31:0] v, input logic [1:0] code);
      case (code)
         2'b00:   align = {v[7:0], 24'd0};
         2'b01:   align = {v[15:0], 16'd0};
         default: align = v;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         sck_q            <= 1'b0;
         cs_q             <= 1'b1;
         sh               <= '0;
         cnt              <= '0;
         tcnt             <= '0;
         w                <= '0;
         ai               <= 1'b0;
         ch               <= '0;
         cap_done         <= 1'b0;
         bus.spi_miso     <= 1'b0;
         bus.address      <= '0;
         bus.data_in      <= '0;
         bus.data_write_n <= '1;
         bus.data_read_n  <= '1;
         bus.busy         <= 1'b0;
         bus.err          <= 1'b0;
      end else begin
         sck_q <= bus.spi_clk;
         cs_q  <= bus.spi_cs_n;
         if (state != IDLE && bus.spi_cs_n) begin
            state            <= IDLE;
            bus.busy         <= 1'b0;
            bus.spi_miso     <= 1'b0;
            bus.data_write_n <= '1;
            bus.data_read_n  <= '1;
         end else begin
            case (state)
               IDLE: if (cs_q && !bus.spi_cs_n) begin
                  state    <= HDR;
                  bus.err  <= 1'b0;
                  bus.busy <= 1'b1;
                  cnt      <= '0;
               end
               HDR: if (rise) begin
                  sh  <= sin;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd15) begin
                     cnt         <= '0;
                     tcnt        <= '0;
                     cap_done    <= 1'b0;
                     w           <= hdr_w;
                     ai          <= sin[12];
                     ch          <= CH_W'(sin[11:8]);
                     bus.address <= sin[ADDR_W-1:0];
                     if (int'(sin[11:8]) >= NCH) begin
                        bus.err <= 1'b1;
                        state   <= DROP;
                     end else if (sin[15]) begin
                        state <= WDATA;
                     end else begin
                        state           <= RWAIT;
                        bus.data_read_n <= strobe(CH_W'(sin[11:8]), hdr_w);
                     end
                  end
               end
               WDATA: if (rise) begin
                  sh  <= sin;
                  cnt <= cnt + 6'd1;
                  if (cnt == last_idx) begin
                     cnt              <= '0;
                     bus.data_in      <= fit(sin, w);
                     bus.data_write_n <= strobe(ch, w);
                     state            <= WSTB;
                  end
               end
               WSTB: begin
                  bus.data_write_n <= '1;
                  if (ai) bus.address <= bus.address + step;
                  state <= WDATA;
               end
               RWAIT: begin
                  if (rise && cnt != 6'd8) cnt <= cnt + 6'd1;
                  if (!cap_done) begin
                     if (sel_rdy) begin
                        sh              <= align(fit(sel_dat, w), w);
                        cap_done        <= 1'b1;
                        bus.data_read_n <= '1;
                     end else if (tcnt == 5'(TIMEOUT - 1)) begin
                        sh              <= '1;
                        bus.err         <= 1'b1;
                        cap_done        <= 1'b1;
                        bus.data_read_n <= '1;
                     end else begin
                        tcnt <= tcnt + 5'd1;
                     end
                  end else if (cnt == 6'd8) begin
                     state        <= RDATA;
                     bus.spi_miso <= sh[31];
                     cnt          <= '0;
                  end
               end
               RDATA: begin
                  // The fall that ends the turnaround byte must not advance the first bit.
                  if (rise) begin
                     cnt <= cnt + 6'd1;
                     if (cnt == last_idx) begin
                        state           <= RWAIT;
                        bus.spi_miso    <= 1'b0;
                        cnt             <= '0;
                        tcnt            <= '0;
                        cap_done        <= 1'b0;
                        bus.data_read_n <= strobe(ch, w);
                        if (ai) bus.address <= bus.address + step;
                     end
                  end else if (fall && cnt != 6'd0) begin
                     sh           <= {sh[30:0], 1'b0};
                     bus.spi_miso <= sh[30];
                  end
               end
               DROP: bus.spi_miso <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_periph_bridge.sv
// Directed bench: bus monitor checks every strobe against an expectation queue built from header rules.
module tb_spi_periph_bridge;
   localparam int ADDR_W  = 6;
   localparam int NCH     = 4;
   localparam int TIMEOUT = 16;

   typedef struct { int ch; int w; int addr; logic [31:0] data; } wr_t;
   typedef struct { int ch; int w; int addr; int len; } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_periph_bridge_if #(.ADDR_W(ADDR_W), .NCH(NCH)) bif ();
   spi_periph_bridge #(.ADDR_W(ADDR_W), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bus(bif)
   );

   int n_chk  = 0;
   int n_pass = 0;
   wr_t exp_wr[$];
   rd_t exp_rd[$];
   logic [31:0] rd_val [NCH];
   int          rd_dly [NCH];
   int          act_cnt[NCH];
   logic [NCH-1:0] noise_rdy;
   int  last_len;
   logic [31:0] got;
   logic [31:0] junk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Peripheral model: ready pulses rd_dly clk after the strobe first appears (-1 = never).
   initial begin
      for (int c = 0; c < NCH; c++) act_cnt[c] = 0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            if (bif.data_read_n[2*c +: 2] != 2'b11) act_cnt[c] = act_cnt[c] + 1;
            else act_cnt[c] = 0;
            bif.data_ready[c] = noise_rdy[c] |
               (act_cnt[c] != 0 && rd_dly[c] >= 0 && act_cnt[c] == rd_dly[c] + 1);
            bif.data_out[32*c +: 32] = rd_val[c];
         end
      end
   end

   initial begin : mon
      int nw, wch, nr, rch, run_len, run_ch, run_addr;
      logic [1:0] wc, rc, run_w;
      logic rd_run;
      wr_t e;
      rd_t r;
      rd_run = 1'b0;
      run_len = 0; run_ch = 0; run_addr = 0; run_w = 2'b11;
      forever begin
         @(negedge clk);
         nw = 0; wch = 0; nr = 0; rch = 0; wc = 2'b11; rc = 2'b11;
         for (int c = 0; c < NCH; c++) begin
            if (bif.data_write_n[2*c +: 2] != 2'b11) begin
               nw++; wch = c; wc = bif.data_write_n[2*c +: 2];
            end
            if (bif.data_read_n[2*c +: 2] != 2'b11) begin
               nr++; rch = c; rc = bif.data_read_n[2*c +: 2];
            end
         end
         if (nw != 0) begin
            check("wr_onehot", nw, 1);
            check("wr_pending", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               e = exp_wr.pop_front();
               check("wr_ch", wch, e.ch);
               check("wr_width", 32'(wc), e.w);
               check("wr_addr", 32'(bif.address), e.addr);
               check("wr_data", bif.data_in, e.data);
            end
         end
         if (nr != 0) begin
            if (!rd_run) begin
               check("rd_onehot", nr, 1);
               rd_run = 1'b1; run_len = 1; run_ch = rch; run_w = rc;
               run_addr = int'(bif.address);
            end else begin
               run_len++;
               check("rd_addr_stable", 32'(bif.address), run_addr);
            end
         end else if (rd_run) begin
            rd_run = 1'b0;
            last_len = run_len;
            check("rd_pending", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
               r = exp_rd.pop_front();
               check("rd_ch", run_ch, r.ch);
               check("rd_width", 32'(run_w), r.w);
               check("rd_addr", run_addr, r.addr);
               if (r.len >= 0) check("rd_len", run_len, r.len);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] beat_val(input logic [31:0] v, input int w);
      return (w == 0) ? (v & 32'hFF) : (w == 1) ? (v & 32'hFFFF) : v;
   endfunction

   task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] g);
      g = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bif.spi_mosi = v[i];
         repeat (3) @(negedge clk);
         g = {g[30:0], bif.spi_miso};
         bif.spi_clk = 1'b1;
         repeat (3) @(negedge clk);
         bif.spi_clk = 1'b0;
      end
   endtask

   task automatic frame_begin;
      bif.spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_frame", 32'(bif.busy), 1);
   endtask

   task automatic frame_end;
      repeat (3) @(negedge clk);
      bif.spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      check("busy_idle", 32'(bif.busy), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_miso"}, 32'(bif.spi_miso), 0);
      check({tag, "_addr"}, 32'(bif.address), 0);
      check({tag, "_din"}, bif.data_in, 0);
      check({tag, "_wr_n"}, 32'(bif.data_write_n), 32'hFF);
      check({tag, "_rd_n"}, 32'(bif.data_read_n), 32'hFF);
      check({tag, "_busy"}, 32'(bif.busy), 0);
      check({tag, "_err"}, 32'(bif.err), 0);
   endtask

   task automatic write_frame(input logic [15:0] hdr, input logic [31:0] d0, d1, d2, input int nb);
      logic [31:0] d[3];
      int w, addr;
      wr_t e;
      d[0] = d0; d[1] = d1; d[2] = d2;
      w = (hdr[14:13] == 2'b11) ? 2 : int'(hdr[14:13]);
      addr = int'(hdr[7:0]) % (1 << ADDR_W);
      for (int b = 0; b < nb; b++) begin
         e.ch = int'(hdr[11:8]); e.w = w; e.addr = addr; e.data = beat_val(d[b], w);
         exp_wr.push_back(e);
         if (hdr[12]) addr = (addr + (1 << w)) % (1 << ADDR_W);
      end
      frame_begin();
      spi_bits({16'd0, hdr}, 16, junk);
      for (int b = 0; b < nb; b++) spi_bits(d[b], 8 << w, junk);
      frame_end();
   endtask

   // Every completed beat re-arms the strobe, so a trailing prefetch (length unchecked) follows.
   task automatic read_frame(input logic [15:0] hdr, input int nb, output logic [31:0] g);
      int w, ch, addr, len;
      logic in_time;
      logic [31:0] expv, ta;
      rd_t r;
      w = (hdr[14:13] == 2'b11) ? 2 : int'(hdr[14:13]);
      ch = int'(hdr[11:8]);
      addr = int'(hdr[7:0]) % (1 << ADDR_W);
      in_time = rd_dly[ch] >= 0 && rd_dly[ch] < TIMEOUT;
      len = in_time ? rd_dly[ch] + 1 : TIMEOUT;
      expv = beat_val(in_time ? rd_val[ch] : 32'hFFFF_FFFF, w);
      for (int b = 0; b <= nb; b++) begin
         r.ch = ch; r.w = w; r.addr = addr; r.len = (b == nb) ? -1 : len;
         exp_rd.push_back(r);
         if (hdr[12]) addr = (addr + (1 << w)) % (1 << ADDR_W);
      end
      g = '0;
      frame_begin();
      spi_bits({16'd0, hdr}, 16, junk);
      for (int b = 0; b < nb; b++) begin
         spi_bits(32'd0, 8, ta);
         check("rd_turnaround", ta, 0);
         spi_bits(32'd0, 8 << w, g);
         check("rd_data", g, expv);
      end
      frame_end();
   endtask

   initial begin
      bif.spi_cs_n = 1'b1; bif.spi_clk = 1'b0; bif.spi_mosi = 1'b0;
      noise_rdy = '0;
      last_len = 0;
      for (int c = 0; c < NCH; c++) begin
         rd_val[c] = 32'h0A0B_0C00 + 32'(c); rd_dly[c] = -1;
      end
      rd_val[1] = 32'h1234_5678; rd_dly[1] = 3;
      repeat (3) @(negedge clk);
      check_reset("in_rst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("post_rst");

      // word write to ch2 addr 3
      write_frame(16'hC203, 32'hDEAD_BEEF, 0, 0, 1);
      check("lit_din_word", bif.data_in, 32'hDEAD_BEEF);
      check("lit_addr_word", 32'(bif.address), 3);

      // byte read from ch1 addr 5, ready 3 clk after strobe
      read_frame(16'h0105, 1, got);
      check("lit_rd_byte", got, 32'h78);
      check("lit_rd_len", last_len, 4);

      // half-word autoinc write burst
      write_frame(16'hB000, 32'h1111, 32'h2222, 32'h3333, 3);
      check("lit_din_burst", bif.data_in, 32'h3333);
      check("lit_addr_burst", 32'(bif.address), 6);

      // half-word autoinc read burst, immediate ready
      rd_val[1] = 32'hCAFE_BABE; rd_dly[1] = 0;
      read_frame(16'h3102, 2, got);
      check("lit_rd_half", got, 32'hBABE);

      // timeout on ch3 with ready noise on ch0
      noise_rdy[0] = 1'b1;
      read_frame(16'h4300, 1, got);
      noise_rdy[0] = 1'b0;
      check("lit_rd_timeout", got, 32'hFFFF_FFFF);
      check("err_retained", 32'(bif.err), 1);

      // bad channel: err clears on CS fall, then sets; MISO stays low
      frame_begin();
      check("err_cleared", 32'(bif.err), 0);
      spi_bits(32'h0700, 16, junk);
      check("err_badch", 32'(bif.err), 1);
      spi_bits(32'hFFFF, 16, got);
      check("drop_miso", got, 0);
      frame_end();
      check("err_after_drop", 32'(bif.err), 1);

      // abort after 20 of 32 data bits
      frame_begin();
      spi_bits(32'hC203, 16, junk);
      spi_bits(32'h000D_EADB, 20, junk);
      bif.spi_cs_n = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bif.busy), 0);
      check("abort_wr_n", 32'(bif.data_write_n), 32'hFF);
      repeat (4) @(negedge clk);
      write_frame(16'h8010, 32'hA5, 0, 0, 1);
      check("lit_din_after_abort", bif.data_in, 32'hA5);
      check("lit_addr_after_abort", 32'(bif.address), 32'h10);

      // reset in the middle of a stalled read
      rd_dly[1] = -1;
      exp_rd.push_back('{ch: 1, w: 0, addr: 5, len: -1});
      frame_begin();
      spi_bits(32'h0105, 16, junk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_rst");
      bif.spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      check("wr_queue_empty", 32'(exp_wr.size()), 0);
      check("rd_queue_empty", 32'(exp_rd.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
